// File: rtl/given_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : given_cache_control
// Brief    : Sequencing FSM for a direct-mapped 8-set write-back cache.
//            Handles hit/miss decisions, write-back/fill handshakes with
//            physical memory, and saturating hit/miss statistics.
// Revision : 1.0 - initial release
// ============================================================================
module given_cache_control #(
    parameter int s_mask    = 32,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [s_mask-1:0]    mem_byte_enable256,
    input  logic                 tag_match,
    input  logic                 valid_out,
    input  logic                 dirty_out,
    input  logic                 pmem_resp,
    input  logic                 clr_stats,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 load_data,
    output logic                 load_tag,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 valid_in,
    output logic                 dirty_in,
    output logic [s_mask-1:0]    data_wmask,
    output logic                 data_sel,
    output logic                 addr_sel,
    output logic [cnt_width-1:0] hit_count,
    output logic [cnt_width-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam logic [cnt_width-1:0] c_cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_hit_inc;
    logic                 w_miss_inc;
    logic [cnt_width-1:0] r_hit_count;
    logic [cnt_width-1:0] r_miss_count;

    assign w_req = mem_read | mem_write;
    assign w_hit = valid_out & tag_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are forced low while reset is held so strobes drop without a clock.
    always_comb begin
        w_next     = r_state;
        w_hit_inc  = 1'b0;
        w_miss_inc = 1'b0;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_data  = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        valid_in   = 1'b0;
        dirty_in   = 1'b0;
        data_wmask = '0;
        data_sel   = 1'b0;
        addr_sel   = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            mem_resp  = 1'b1;
                            w_hit_inc = 1'b1;
                            if (mem_write) begin
                                load_data  = 1'b1;
                                data_sel   = 1'b0;
                                data_wmask = mem_byte_enable256;
                                load_dirty = 1'b1;
                                dirty_in   = 1'b1;
                            end
                        end else begin
                            w_miss_inc = 1'b1;
                            w_next     = (valid_out & dirty_out) ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                    if (pmem_resp) begin
                        w_next = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    addr_sel  = 1'b0;
                    if (pmem_resp) begin
                        load_data  = 1'b1;
                        data_sel   = 1'b1;
                        data_wmask = '1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        valid_in   = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b0;
                        w_next     = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // Clear has priority over increment; counters stick at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (clr_stats) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_inc && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + c_cnt_one;
            end
            if (w_miss_inc && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + c_cnt_one;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire
